// File: rtl/light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : light_monitor
// Function : Lamp driver and checker for the traffic-light sequencer. It
//            latches a flashing-red failsafe when it sees a bad code, a bad
//            transition or a stuck light.
// Revision : 1.0
// ============================================================================
module light_monitor #(
    parameter int MAX_DWELL = 16,
    parameter int BLINK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light_in,
    input  logic       clr_fault,
    output logic       lamp_red,
    output logic       lamp_yellow,
    output logic       lamp_green,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [7:0] cycle_cnt
);

    localparam int DW = $clog2(MAX_DWELL + 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [2:0] c_RED = 3'b100;
    localparam logic [2:0] c_YEL = 3'b010;
    localparam logic [2:0] c_GRN = 3'b001;

    localparam logic [1:0] c_FC_NONE    = 2'b00;
    localparam logic [1:0] c_FC_ILLEGAL = 2'b01;
    localparam logic [1:0] c_FC_ORDER   = 2'b10;
    localparam logic [1:0] c_FC_STUCK   = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t          r_state,  w_state;
    logic [2:0]      r_prev,   w_prev;
    logic [DW-1:0]   r_dwell,  w_dwell;
    logic [BW-1:0]   r_blink,  w_blink;
    logic [2:0]      r_lamps,  w_lamps;
    logic            r_fault,  w_fault;
    logic [1:0]      r_code,   w_code;
    logic [7:0]      r_cnt,    w_cnt;

    logic            w_legal;
    logic [2:0]      w_succ;
    logic            w_enter;
    logic [1:0]      w_enter_code;

    assign w_legal = (light_in == c_RED) || (light_in == c_YEL) || (light_in == c_GRN);

    always_comb begin
        w_succ = 3'b000;
        case (r_prev)
            c_GRN:   w_succ = c_YEL;
            c_YEL:   w_succ = c_RED;
            c_RED:   w_succ = c_GRN;
            default: w_succ = 3'b000;
        endcase
    end

    always_comb begin
        w_state      = r_state;
        w_prev       = r_prev;
        w_dwell      = r_dwell;
        w_blink      = r_blink;
        w_lamps      = r_lamps;
        w_fault      = r_fault;
        w_code       = r_code;
        w_cnt        = r_cnt;
        w_enter      = 1'b0;
        w_enter_code = c_FC_NONE;

        case (r_state)
            ST_INIT: begin
                w_lamps = c_RED;
                if (w_legal) begin
                    w_state = ST_RUN;
                    w_lamps = light_in;
                    w_prev  = light_in;
                    w_dwell = DW'(1);
                end
            end
            ST_RUN: begin
                // Checks are ordered so that a bad code outranks a dwell expiry.
                if (!w_legal) begin
                    w_enter      = 1'b1;
                    w_enter_code = c_FC_ILLEGAL;
                end else if ((light_in != r_prev) && (light_in != w_succ)) begin
                    w_enter      = 1'b1;
                    w_enter_code = c_FC_ORDER;
                end else if (light_in == r_prev) begin
                    if ((r_dwell + DW'(1)) == DW'(MAX_DWELL)) begin
                        w_enter      = 1'b1;
                        w_enter_code = c_FC_STUCK;
                    end else begin
                        w_dwell = r_dwell + DW'(1);
                    end
                end else begin
                    w_lamps = light_in;
                    w_prev  = light_in;
                    w_dwell = DW'(1);
                    if ((r_prev == c_RED) && (light_in == c_GRN)) begin
                        w_cnt = r_cnt + 8'd1;
                    end
                end
            end
            ST_FAULT: begin
                if (clr_fault) begin
                    w_state = ST_INIT;
                    w_fault = 1'b0;
                    w_code  = c_FC_NONE;
                    w_lamps = c_RED;
                    w_dwell = '0;
                    w_prev  = 3'b000;
                    w_blink = '0;
                end else if (r_blink == BW'(BLINK_DIV - 1)) begin
                    w_blink = '0;
                    w_lamps = {~r_lamps[2], 2'b00};
                end else begin
                    w_blink = r_blink + BW'(1);
                end
            end
            default: begin
                w_state = ST_INIT;
            end
        endcase

        if (w_enter) begin
            w_state = ST_FAULT;
            w_fault = 1'b1;
            w_code  = w_enter_code;
            w_lamps = c_RED;
            w_blink = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_prev  <= 3'b000;
            r_dwell <= '0;
            r_blink <= '0;
            r_lamps <= c_RED;
            r_fault <= 1'b0;
            r_code  <= c_FC_NONE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state;
            r_prev  <= w_prev;
            r_dwell <= w_dwell;
            r_blink <= w_blink;
            r_lamps <= w_lamps;
            r_fault <= w_fault;
            r_code  <= w_code;
            r_cnt   <= w_cnt;
        end
    end

    assign lamp_red    = r_lamps[2];
    assign lamp_yellow = r_lamps[1];
    assign lamp_green  = r_lamps[0];
    assign fault       = r_fault;
    assign fault_code  = r_code;
    assign cycle_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: doc/light_monitor.md
Name: light_monitor

Overview:
- Downstream stage of the traffic-light sequencer. Consumes its one-hot light code (100 = red, 010 = yellow, 001 = green) and drives the three lamp outputs.
- Checks every code for legality, legal sequence order and stuck-at dwell.
- On any violation, drops into a latched flashing-red failsafe that holds until software clears it.
- Keeps a wrap-around count of completed red-to-green cycles.

Parameters:
- MAX_DWELL, 16: fault when the same legal code is sampled on this many consecutive RUN cycles (minimum 2).
- BLINK_DIV, 4: failsafe half-period in clock cycles (minimum 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- light_in  input  3  one-hot light code from the sequencer.
- clr_fault  input  1  clears a latched fault; honoured only in FAULT.
- lamp_red  output  1  red lamp drive.
- lamp_yellow  output  1  yellow lamp drive.
- lamp_green  output  1  green lamp drive.
- fault  output  1  high while in FAULT.
- fault_code  output  2  00 none, 01 illegal code, 10 illegal transition, 11 stuck.
- cycle_cnt  output  8  number of legal 100->001 transitions seen in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low, and has priority over everything.
- Reset values:
  - State INIT.
  - lamp_red=1, lamp_yellow=0, lamp_green=0.
  - fault=0, fault_code=00, cycle_cnt=0.
  - Internal prev=000, dwell=0, blink_cnt=0.
- All outputs are registered. Lamps follow light_in with 1-cycle latency in RUN.
- Legal codes: 100, 010, 001. Legal successors: 001->010, 010->100, 100->001. Same code is a hold.

INIT state:
- Lamps held at red only.
- Illegal codes are ignored; stay in INIT with no fault.
- Legal code: next state RUN, lamps<=code, prev<=code, dwell<=1.

RUN state, evaluated in priority order on each edge:
1. light_in not a legal code -> FAULT, fault_code<=01.
2. light_in != prev and not the legal successor of prev -> FAULT, fault_code<=10.
3. light_in == prev:
   - If dwell+1 == MAX_DWELL -> FAULT, fault_code<=11.
   - Otherwise dwell<=dwell+1.
4. Legal change: lamps<=code, prev<=code, dwell<=1. If the change is 100->001, cycle_cnt<=cycle_cnt+1 (wraps 255->0).

FAULT state:
- On entry (same edge as the detection):
  - fault<=1.
  - lamp_red<=1, lamp_yellow<=0, lamp_green<=0.
  - blink_cnt<=0.
- Each cycle in FAULT:
  - If blink_cnt==BLINK_DIV-1: blink_cnt<=0 and lamp_red toggles.
  - Otherwise blink_cnt<=blink_cnt+1.
  - Result: red is on for BLINK_DIV cycles, then off for BLINK_DIV cycles.
- light_in is ignored. fault_code is held.
- clr_fault=1 -> next state INIT:
  - fault<=0, fault_code<=00.
  - lamp_red<=1, others 0.
  - dwell<=0, prev<=000.

Other rules:
- clr_fault in INIT or RUN has no effect.
- cycle_cnt is cleared only by reset. It is never cleared by clr_fault.
- Reset asserted mid-FAULT or mid-RUN returns to reset values on that edge.
- Simultaneous rst_n=0 and clr_fault=1: reset wins.
- An illegal code that arrives on the same edge as a dwell expiry reports 01 (priority order above).

Test Plan:
1. Reset, then drive 001,010,100 repeating for 9 cycles -> fault=0 throughout; lamps equal light_in delayed 1 cycle; cycle_cnt=2 after the second 100->001.
2. In RUN at prev=010, drive 011 -> next cycle fault=1, fault_code=01, lamp_red=1, yellow=green=0; red toggles after 4 cycles (BLINK_DIV=4) and stays off 4 cycles.
3. In RUN at prev=001, drive 100 -> fault_code=10. Assert clr_fault for 1 cycle -> next cycle state INIT, fault=0, fault_code=00, red only. Drive 001 -> RUN resumes.
4. Hold 010 for 16 consecutive RUN samples (MAX_DWELL=16) -> fault_code=11 on the edge of the 16th sample. With 15 samples followed by 100 -> no fault.
5. Run 256 legal 100->001 transitions -> cycle_cnt wraps to 0. Then force a fault and clear it -> cycle_cnt unchanged.
6. Assert rst_n=0 together with clr_fault=1 while in FAULT -> all reset values. While in INIT, drive 110 then 000 -> stay in INIT, fault=0.
